// File: rtl/psum_pkg.sv
// Shared types and width helpers for the partial-sum accumulator.
// Holds the FSM state encoding, default parameter values and the clamp limits.
// Used by psum_if, psum_sat_add and psum_accumulator.
package psum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Upstream tree sums eight operands, adding three bits of growth.
  function automatic int in_width(input int width);
    return width + 3;
  endfunction

  // Beat counter width; MAX_LEN is a power of two and 0 encodes MAX_LEN.
  function automatic int len_width(input int max_len);
    return $clog2(max_len);
  endfunction

  // Largest representable two's complement value at acc_w bits.
  function automatic longint sat_max(input int acc_w);
    return (longint'(1) <<< (acc_w - 1)) - 1;
  endfunction

  // Smallest representable two's complement value at acc_w bits.
  function automatic longint sat_min(input int acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction

  localparam int DEF_WIDTH   = 17;
  localparam int DEF_MAX_LEN = 64;
  localparam int DEF_ACC_W   = 26;
  localparam int DEF_IN_W    = in_width(DEF_WIDTH);
  localparam int DEF_LEN_W   = len_width(DEF_MAX_LEN);

endpackage

// File: rtl/psum_if.sv
// Bundle of the accumulator's configuration, input-beat and result handshakes.
// master = upstream/downstream side (testbench or datapath glue), slave = accumulator.
// in_ready is driven combinationally by the slave and may depend on out_ready.
interface psum_if #(
  parameter int IN_W  = psum_pkg::DEF_IN_W,
  parameter int LEN_W = psum_pkg::DEF_LEN_W,
  parameter int ACC_W = psum_pkg::DEF_ACC_W
) ();

  logic [LEN_W-1:0]        cfg_len;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_sum;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_sat;

  modport master (
    output cfg_len, flush, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_sat
  );

  modport slave (
    input  cfg_len, flush, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_sat
  );

endinterface

// File: rtl/psum_sat_add.sv
// Combinational ACC_W signed adder; clamps and flags overflow when PSUM_SAT_EN is defined.
// Latency: zero cycles (pure combinational).
// Backpressure: none; without PSUM_SAT_EN the sum wraps and o_ovf stays 0.
module psum_sat_add
  import psum_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0] i_a,
  input  logic signed [ACC_W-1:0] i_b,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

`ifdef PSUM_SAT_EN
  localparam logic signed [ACC_W:0] L_MAX = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] L_MIN = (ACC_W+1)'(sat_min(ACC_W));

  logic signed [ACC_W:0] w_wide;

  // one guard bit makes the sum exact, then clamp back into ACC_W range
  always_comb begin
    w_wide = (ACC_W+1)'(i_a) + (ACC_W+1)'(i_b);
    o_sum  = w_wide[ACC_W-1:0];
    o_ovf  = 1'b0;
    if (w_wide > L_MAX) begin
      o_sum = L_MAX[ACC_W-1:0];
      o_ovf = 1'b1;
    end else if (w_wide < L_MIN) begin
      o_sum = L_MIN[ACC_W-1:0];
      o_ovf = 1'b1;
    end
  end
`else
  // plain modular add; overflow is never reported
  always_comb begin
    o_sum = i_a + i_b;
    o_ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cfg_len adder-tree beats into one dot product (optional clamp: PSUM_SAT_EN).
// Latency: final beat accepted in cycle t -> out_valid/out_acc registered in cycle t+1.
// Backpressure: only the final beat stalls, when the result register is full and out_ready=0.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic   clk,
  input  logic   rst,
  psum_if.slave  bus
);

  localparam int IN_W  = in_width(WIDTH);
  localparam int LEN_W = len_width(MAX_LEN);

  if (ACC_W < IN_W) begin : g_bad_acc_w
    $error("psum_accumulator: ACC_W must be at least WIDTH+3");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LEN_W-1:0]        r_cnt;
  logic [LEN_W-1:0]        r_len_q;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_sat;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_acc;
  logic                    r_out_sat;

  logic                    w_first;
  logic [LEN_W-1:0]        w_len_eff;
  logic                    w_final;
  logic                    w_stall;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_pop;
  logic signed [ACC_W-1:0] w_addend_a;
  logic signed [ACC_W-1:0] w_addend_b;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_ovf;
  logic                    w_sat_nxt;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state: flush or the final beat always returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush)     w_state_nxt = IDLE;
    else if (w_accept) w_state_nxt = w_final ? IDLE : ACCUM;
  end

  // handshake decode; the length in force is cfg_len on the first beat, latched thereafter
  always_comb begin
    w_first    = (r_state == IDLE);
    w_len_eff  = w_first ? bus.cfg_len : r_len_q;
    // a latched length of 0 wraps to MAX_LEN-1 here, giving MAX_LEN beats
    w_final    = (r_cnt == w_len_eff - LEN_W'(1));
    w_stall    = w_final && r_out_valid && !bus.out_ready;
    w_in_ready = !bus.flush && !w_stall;
    w_accept   = bus.in_valid && w_in_ready;
    w_pop      = r_out_valid && bus.out_ready;
  end

  // first beat adds to zero so the previous dot product is discarded
  always_comb begin
    w_addend_a = w_first ? '0 : r_acc;
    w_addend_b = ACC_W'(bus.in_sum);
    w_sat_nxt  = w_ovf || (!w_first && r_sat);
  end

  psum_sat_add #(.ACC_W(ACC_W)) u_add (
    .i_a   (w_addend_a),
    .i_b   (w_addend_b),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // beat counter, latched length and running sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_len_q <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_final ? '0 : r_cnt + LEN_W'(1);
      if (w_first) r_len_q <= bus.cfg_len;
      r_acc <= w_sum;
      r_sat <= w_sat_nxt;
    end
  end

  // result register: a final beat reloads it even while the old result is being popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_accept && w_final) begin
      r_out_valid <= 1'b1;
      r_out_acc   <= w_sum;
      r_out_sat   <= w_sat_nxt;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: vector table, corner sequences, random vs model.
// Expected values come from constants and a beat-counting arithmetic model.
// Honours PSUM_SAT_EN for the saturation expectations.
module tb_psum_accumulator;
  import psum_pkg::*;

  localparam int IN_W   = 20;
  localparam int LEN_W  = 6;
  localparam int ACC_W  = 26;
  localparam int ACC_WS = 21;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_if #(.IN_W(IN_W), .LEN_W(LEN_W), .ACC_W(ACC_W))  bus_d ();
  psum_if #(.IN_W(IN_W), .LEN_W(LEN_W), .ACC_W(ACC_WS)) bus_s ();

  psum_accumulator #(.WIDTH(17), .MAX_LEN(64), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  psum_accumulator #(.WIDTH(17), .MAX_LEN(64), .ACC_W(ACC_WS)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int     len;
    bit     flush;
    bit     vld;
    int     sum;
    bit     ordy;
    bit     e_irdy;
    bit     e_ovld;
    longint e_acc;
  } vec_t;

  function automatic vec_t mk(input int len, input bit fl, input bit v, input int s,
                              input bit r, input bit eir, input bit eov, input longint eacc);
    vec_t x;
    x.len = len; x.flush = fl; x.vld = v; x.sum = s; x.ordy = r;
    x.e_irdy = eir; x.e_ovld = eov; x.e_acc = eacc;
    return x;
  endfunction

  // reference arithmetic: wrap or clamp a mathematically exact value into w bits
  function automatic longint fit(input longint x, input int w, output bit ov);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    longint m  = longint'(1) <<< w;
    longint y  = x;
    ov = 1'b0;
`ifdef PSUM_SAT_EN
    if (y > hi) begin ov = 1'b1; y = hi; end
    if (y < lo) begin ov = 1'b1; y = lo; end
`else
    while (y > hi) y = y - m;
    while (y < lo) y = y + m;
`endif
    return y;
  endfunction

  task automatic drive_d(input int len, input bit fl, input bit v, input int s, input bit r);
    logic [31:0] sv;
    sv = s;
    bus_d.cfg_len   = LEN_W'(len);
    bus_d.flush     = fl;
    bus_d.in_valid  = v;
    bus_d.in_sum    = sv[IN_W-1:0];
    bus_d.out_ready = r;
  endtask

  task automatic pulse_reset();
    drive_d(0, 0, 0, 0, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  // model state for the random phase
  int     m_cnt, m_len;
  longint m_acc, m_out;
  bit     m_sat, m_osat, m_ov;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive_d(0, 0, 0, 0, 1);
    bus_s.cfg_len = '0; bus_s.flush = 1'b0; bus_s.in_valid = 1'b0;
    bus_s.in_sum = '0; bus_s.out_ready = 1'b1;

    // reset state
    #3;
    chk("rst_out_valid", bus_d.out_valid, 0);
    chk("rst_out_acc",   bus_d.out_acc,   0);
    chk("rst_out_sat",   bus_d.out_sat,   0);
    chk("rst_in_ready",  bus_d.in_ready,  1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // basic accumulation, negative single-beat, fresh sum afterwards
    tbl.push_back(mk(4, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 2, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 3, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 4, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 0, 0, 1, 1, 1, 10));
    tbl.push_back(mk(1, 0, 1, -524288, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 5, 1, 1, 1, -524288));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 5));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
    // backpressure: two len-2 dot products with out_ready low
    tbl.push_back(mk(2, 0, 1, 5, 0, 1, 0, 0));
    tbl.push_back(mk(2, 0, 1, 5, 0, 1, 0, 0));
    tbl.push_back(mk(2, 0, 1, 7, 0, 1, 1, 10));
    tbl.push_back(mk(2, 0, 1, 7, 0, 0, 1, 10));
    tbl.push_back(mk(2, 0, 1, 7, 0, 0, 1, 10));
    tbl.push_back(mk(2, 0, 1, 7, 1, 1, 1, 10));
    tbl.push_back(mk(2, 0, 0, 0, 1, 1, 1, 14));
    tbl.push_back(mk(2, 0, 0, 0, 1, 1, 0, 0));
    // flush mid-accumulation drops the beat presented with it
    tbl.push_back(mk(4, 0, 1, 100, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 200, 1, 1, 0, 0));
    tbl.push_back(mk(4, 1, 1, 300, 1, 0, 0, 0));
    tbl.push_back(mk(4, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4, 0, 0, 0, 1, 1, 1, 4));
    tbl.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0));

    foreach (tbl[i]) begin
      drive_d(tbl[i].len, tbl[i].flush, tbl[i].vld, tbl[i].sum, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i),  bus_d.in_ready,  tbl[i].e_irdy);
      chk($sformatf("vec%0d_out_valid", i), bus_d.out_valid, tbl[i].e_ovld);
      if (tbl[i].e_ovld) begin
        chk($sformatf("vec%0d_out_acc", i), bus_d.out_acc, tbl[i].e_acc);
        chk($sformatf("vec%0d_out_sat", i), bus_d.out_sat, 0);
      end
      @(posedge clk); #1;
    end
    drive_d(0, 0, 0, 0, 1);

    // saturation on the narrow instance: three beats of the largest positive tree sum
    bus_s.cfg_len = LEN_W'(3); bus_s.in_valid = 1'b1; bus_s.in_sum = IN_W'(524287);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("sat_in_ready%0d", k), bus_s.in_ready, 1);
      @(posedge clk); #1;
    end
    bus_s.in_valid = 1'b0;
    chk("sat_out_valid", bus_s.out_valid, 1);
`ifdef PSUM_SAT_EN
    chk("sat_out_acc", bus_s.out_acc, 1048575);
    chk("sat_out_sat", bus_s.out_sat, 1);
`else
    chk("sat_out_acc", bus_s.out_acc, -524291);
    chk("sat_out_sat", bus_s.out_sat, 0);
`endif
    @(posedge clk); #1;
    chk("sat_drained", bus_s.out_valid, 0);

    // asynchronous reset with a pending result and a half-finished dot product
    drive_d(1, 0, 1, 9, 0);
    @(posedge clk); #1;
    drive_d(4, 0, 1, 1, 0);
    @(posedge clk); #1;
    drive_d(4, 0, 1, 2, 0);
    @(posedge clk); #1;
    drive_d(4, 0, 0, 0, 0);
    chk("arst_pre_valid", bus_d.out_valid, 1);
    chk("arst_pre_acc",   bus_d.out_acc,   9);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus_d.out_valid, 0);
    chk("arst_out_acc",   bus_d.out_acc,   0);
    chk("arst_out_sat",   bus_d.out_sat,   0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("arst_in_ready", bus_d.in_ready, 1);
    @(posedge clk); #1;
    drive_d(2, 0, 1, 3, 1);
    @(posedge clk); #1;
    drive_d(2, 0, 1, 4, 1);
    @(posedge clk); #1;
    drive_d(2, 0, 0, 0, 1);
    chk("arst_after_valid", bus_d.out_valid, 1);
    chk("arst_after_acc",   bus_d.out_acc,   7);

    // random traffic against the beat-counting model
    pulse_reset();
    m_cnt = 0; m_len = 0; m_acc = 0; m_out = 0; m_sat = 0; m_osat = 0; m_ov = 0;
    for (int c = 0; c < 3000; c++) begin
      int     len_in, len_use;
      bit     fl, v, r, first, fin, e_rdy, load, ov;
      longint s;
      len_in = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 5));
      fl     = ($urandom_range(0, 31) == 0);
      v      = ($urandom_range(0, 3) != 0);
      r      = ($urandom_range(0, 2) != 0);
      bus_d.cfg_len   = LEN_W'(len_in);
      bus_d.flush     = fl;
      bus_d.in_valid  = v;
      bus_d.in_sum    = IN_W'($urandom);
      bus_d.out_ready = r;
      s = longint'(bus_d.in_sum);

      @(negedge clk);
      first   = (m_cnt == 0);
      len_use = first ? ((len_in == 0) ? 64 : len_in) : m_len;
      fin     = (m_cnt + 1 == len_use);
      e_rdy   = !fl && !(fin && m_ov && !r);
      chk("rnd_in_ready",  bus_d.in_ready,  e_rdy);
      chk("rnd_out_valid", bus_d.out_valid, m_ov);
      if (m_ov) begin
        chk("rnd_out_acc", bus_d.out_acc, m_out);
        chk("rnd_out_sat", bus_d.out_sat, m_osat);
      end

      load = 1'b0;
      if (fl) begin
        m_cnt = 0;
      end else if (v && e_rdy) begin
        if (first) begin
          m_len = len_use;
          m_acc = s;
          m_sat = 1'b0;
        end else begin
          m_acc = fit(m_acc + s, ACC_W, ov);
          m_sat = m_sat | ov;
        end
        m_cnt++;
        if (m_cnt == m_len) begin
          load  = 1'b1;
          m_cnt = 0;
        end
      end
      if (load) begin
        m_ov = 1'b1; m_out = m_acc; m_osat = m_sat;
      end else if (m_ov && r) begin
        m_ov = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
